// File: rtl/pde_pkg.sv
// Shared types and fixed-point helpers for the Jacobi PE grid.
// Helpers work at fixed 64/32-bit widths; callers size-cast to DW.
package pde_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_DONE} state_t;

  localparam int DW_DEF   = 16;
  localparam int FRAC_DEF = 8;

  // Arithmetic shift by frac, then clamp into a signed dw-bit range.
  function automatic logic signed [31:0] sat_shift(input logic signed [63:0] s,
                                                   input int frac, input int dw);
    logic signed [63:0] t, hi, lo;
    t  = s >>> frac;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (t > hi)      return hi[31:0];
    else if (t < lo) return lo[31:0];
    else             return t[31:0];
  endfunction

  // |a - b| computed one bit wider than the operands so it cannot wrap.
  function automatic logic [32:0] abs_diff(input logic signed [31:0] a,
                                           input logic signed [31:0] b);
    logic signed [32:0] d;
    d = 33'(a) - 33'(b);
    return (d < 0) ? 33'(-d) : 33'(d);
  endfunction
endpackage

// File: rtl/pe_cell.sv
// One grid point: weighted 4-neighbour + source update, u register, delta flag.
module pe_cell import pde_pkg::*; #(
  parameter int DW   = DW_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] wx,
  input  logic [DW-1:0] wy,
  input  logic [DW-1:0] w,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] ul,
  input  logic [DW-1:0] ur,
  input  logic [DW-1:0] uu,
  input  logic [DW-1:0] ud,
  input  logic [DW-1:0] tol,
  output logic [DW-1:0] u,
  output logic          ok
);
  localparam int PW = 2 * DW;
  localparam int SW = 2 * DW + 2;

  logic signed [PW-1:0] pl, pr, pu, pd, pb;
  logic signed [SW-1:0] sum;
  logic        [DW-1:0] un;

  // Five full-width products; their sum always fits in 2*DW+2 bits.
  always_comb begin
    pl  = PW'(signed'(wx)) * PW'(signed'(ul));
    pr  = PW'(signed'(wx)) * PW'(signed'(ur));
    pu  = PW'(signed'(wy)) * PW'(signed'(uu));
    pd  = PW'(signed'(wy)) * PW'(signed'(ud));
    pb  = PW'(signed'(w))  * PW'(signed'(b));
    sum = SW'(pl) + SW'(pr) + SW'(pu) + SW'(pd) + SW'(pb);
    un  = DW'(sat_shift(64'(sum), FRAC, DW));
    ok  = abs_diff(32'(signed'(un)), 32'(signed'(u))) <= 33'(tol);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      u <= '0;
    else if (clr) u <= '0;
    else if (en)  u <= un;
  end
endmodule

// File: rtl/pe_grid_solver.sv
// ROWS x COLS Jacobi solver: streamed source load, one full sweep per clock,
// convergence/iteration-limit stop and registered addressed readout.
module pe_grid_solver import pde_pkg::*; #(
  parameter int ROWS   = 5,
  parameter int COLS   = 5,
  parameter int DW     = DW_DEF,
  parameter int FRAC   = FRAC_DEF,
  parameter int ITER_W = 10
) (
  input  logic                           CLK,
  input  logic                           R,
  input  logic                           start,
  input  logic [DW-1:0]                  Wx,
  input  logic [DW-1:0]                  Wy,
  input  logic [DW-1:0]                  W,
  input  logic [DW-1:0]                  bnd,
  input  logic [ITER_W-1:0]              max_iter,
  input  logic [DW-1:0]                  tol,
  input  logic                           load_valid,
  input  logic [DW-1:0]                  load_data,
  output logic                           load_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           converged,
  output logic [ITER_W-1:0]              iter_count,
  input  logic [$clog2(ROWS*COLS)-1:0]   rd_addr,
  output logic [DW-1:0]                  rd_data
);
  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(N);

  state_t               state_q, state_d;
  logic [DW-1:0]        bnd_q, tol_q;
  logic [ITER_W-1:0]    maxi_q;
  logic [AW-1:0]        idx;
  logic [N-1:0][DW-1:0] b_q, u;
  logic [N-1:0]         ok;
  logic                 conv_all, accept, clr, en;

  assign conv_all = &ok;
  assign accept   = (state_q == S_LOAD) && load_valid;
  assign clr      = (state_q == S_IDLE) && start;
  assign en       = (state_q == S_ITER);

  always_ff @(posedge CLK or posedge R) begin
    if (R) state_q <= S_IDLE;
    else   state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: if (accept && idx == AW'(N - 1))
                state_d = (maxi_q == '0) ? S_DONE : S_ITER;
      S_ITER: if (conv_all || (iter_q_next() == maxi_q)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state_q == S_LOAD);
    busy       = (state_q == S_LOAD) || (state_q == S_ITER);
    done       = (state_q == S_DONE);
  end

  function automatic logic [ITER_W-1:0] iter_q_next();
    return iter_count + ITER_W'(1);
  endfunction

  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      bnd_q      <= '0;
      tol_q      <= '0;
      maxi_q     <= '0;
      iter_count <= '0;
      converged  <= 1'b0;
      idx        <= '0;
      b_q        <= '0;
    end else begin
      if (clr) begin
        bnd_q      <= bnd;
        tol_q      <= tol;
        maxi_q     <= max_iter;
        iter_count <= '0;
        converged  <= 1'b0;
        idx        <= '0;
      end
      if (accept) begin
        b_q[idx] <= load_data;
        idx      <= idx + AW'(1);
      end
      if (en) begin
        iter_count <= iter_q_next();
        if (conv_all) converged <= 1'b1;
      end
    end
  end

  // Off-grid neighbours are replaced by the captured boundary value here.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int K = r * COLS + c;
      logic [DW-1:0] ul, ur, uu, ud;
      if (c == 0) begin : g_l
        assign ul = bnd_q;
      end else begin : g_l
        assign ul = u[K-1];
      end
      if (c == COLS - 1) begin : g_r
        assign ur = bnd_q;
      end else begin : g_r
        assign ur = u[K+1];
      end
      if (r == 0) begin : g_u
        assign uu = bnd_q;
      end else begin : g_u
        assign uu = u[K-COLS];
      end
      if (r == ROWS - 1) begin : g_d
        assign ud = bnd_q;
      end else begin : g_d
        assign ud = u[K+COLS];
      end
      pe_cell #(.DW(DW), .FRAC(FRAC)) u_cell (
        .clk(CLK), .rst(R), .clr(clr), .en(en),
        .wx(Wx), .wy(Wy), .w(W), .b(b_q[K]),
        .ul(ul), .ur(ur), .uu(uu), .ud(ud),
        .tol(tol_q), .u(u[K]), .ok(ok[K])
      );
    end
  end

  always_ff @(posedge CLK or posedge R) begin
    if (R) rd_data <= '0;
    else   rd_data <= ({{(32-AW){1'b0}}, rd_addr} < 32'(N)) ? u[rd_addr] : '0;
  end
endmodule

// File: tb/tb_pe_grid_solver.sv
// Directed bench: a 5x5 instance for solve behaviour and a 3x4 instance for
// stalled loading; expected values are hand-derived fixed-point results.
module tb_pe_grid_solver;
  logic CLK = 1'b0;
  logic R   = 1'b1;
  always #5 CLK = ~CLK;

  logic        start = 0, load_valid = 0, load_ready, busy, done, converged;
  logic [15:0] Wx = 0, Wy = 0, W = 0, bnd = 0, tol = 0, load_data = 0, rd_data;
  logic [9:0]  max_iter = 0, iter_count;
  logic [4:0]  rd_addr = 0;

  logic        start_b = 0, load_valid_b = 0, load_ready_b, busy_b, done_b, converged_b;
  logic [15:0] load_data_b = 0, rd_data_b;
  logic [9:0]  iter_count_b;
  logic [3:0]  rd_addr_b = 0;

  pe_grid_solver #(.ROWS(5), .COLS(5)) dut (
    .CLK(CLK), .R(R), .start(start), .Wx(Wx), .Wy(Wy), .W(W), .bnd(bnd),
    .max_iter(max_iter), .tol(tol), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .busy(busy), .done(done), .converged(converged),
    .iter_count(iter_count), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // Small grid: pure source passthrough with W = 1.0 and no neighbour terms.
  pe_grid_solver #(.ROWS(3), .COLS(4)) dut_b (
    .CLK(CLK), .R(R), .start(start_b), .Wx(16'h0000), .Wy(16'h0000), .W(16'h0100),
    .bnd(16'h0000), .max_iter(10'd1), .tol(16'h0000), .load_valid(load_valid_b),
    .load_data(load_data_b), .load_ready(load_ready_b), .busy(busy_b), .done(done_b),
    .converged(converged_b), .iter_count(iter_count_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b)
  );

  int total = 0, bad = 0;
  logic [15:0] src [25];
  logic [15:0] srcb [12];
  logic [15:0] d;
  int lat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cfg(input logic [15:0] wx_i, wy_i, w_i, bnd_i, tol_i, input logic [9:0] mi);
    Wx = wx_i; Wy = wy_i; W = w_i; bnd = bnd_i; tol = tol_i; max_iter = mi;
  endtask

  task automatic fill(input logic [15:0] v);
    for (int k = 0; k < 25; k++) src[k] = v;
  endtask

  task automatic start_load();
    @(negedge CLK); start = 1;
    @(negedge CLK); start = 0;
    for (int k = 0; k < 25; k++) begin
      load_valid = 1; load_data = src[k];
      @(negedge CLK);
    end
    load_valid = 0; load_data = 16'hDEAD;
  endtask

  // lat = clock edges from the start edge to the first cycle done is seen.
  task automatic run_a(output int l);
    start_load();
    l = 25;
    while (!done && l < 400) begin
      @(negedge CLK); l++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic rd_a(input int a, output logic [15:0] v);
    rd_addr = 5'(a);
    @(negedge CLK);
    v = rd_data;
  endtask

  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", load_ready, 0);
    chk("rst_conv", converged, 0);
    chk("rst_iter", iter_count, 0);
    chk("rst_rd", rd_data, 0);
    repeat (2) @(negedge CLK);
    R = 0;

    // Zero source: first sweep has zero delta; LOAD 25 + ITER 1, done on the 27th cycle.
    fill(16'h0000);
    cfg(16'h0040, 16'h0040, 16'h0040, 16'h0000, 16'h0000, 10'd10);
    run_a(lat);
    chk("zero_lat", lat, 26);
    chk("zero_conv", converged, 1);
    chk("zero_iter", iter_count, 1);
    chk("zero_busy", busy, 0);

    // Point source, one sweep: only the centre picks up 0.25*1.0.
    fill(16'h0000); src[12] = 16'h0100;
    cfg(16'h0040, 16'h0040, 16'h0040, 16'h0000, 16'h0000, 10'd1);
    run_a(lat);
    chk("pt1_conv", converged, 0);
    chk("pt1_iter", iter_count, 1);
    rd_a(12, d); chk("pt1_c", d, 16'h0040);
    rd_a(11, d); chk("pt1_w", d, 16'h0000);
    rd_a(0,  d); chk("pt1_corner", d, 16'h0000);

    // Two sweeps: neighbours get 0.25*0x40, centre stays 0x40.
    max_iter = 10'd2;
    run_a(lat);
    chk("pt2_iter", iter_count, 2);
    rd_a(12, d); chk("pt2_c", d, 16'h0040);
    rd_a(11, d); chk("pt2_w", d, 16'h0010);
    rd_a(13, d); chk("pt2_e", d, 16'h0010);
    rd_a(7,  d); chk("pt2_n", d, 16'h0010);
    rd_a(17, d); chk("pt2_s", d, 16'h0010);
    rd_a(6,  d); chk("pt2_diag", d, 16'h0000);

    // Iteration limit stops the solve unconverged.
    max_iter = 10'd3;
    run_a(lat);
    chk("lim_lat", lat, 28);
    chk("lim_iter", iter_count, 3);
    chk("lim_conv", converged, 0);
    rd_a(12, d); chk("pt3_c", d, 16'h0050);
    rd_a(31, d); chk("rd_oob", d, 16'h0000);

    // Positive saturation everywhere, including boundary-fed cells.
    fill(16'h7FFF);
    cfg(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 10'd1);
    run_a(lat);
    for (int k = 0; k < 25; k++) begin
      rd_a(k, d); chk($sformatf("satp_%0d", k), d, 16'h7FFF);
    end

    // All operands 0x8000: every product is (-1)*(-1)-scaled, hence positive.
    fill(16'h8000);
    cfg(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 10'd1);
    run_a(lat);
    rd_a(0,  d); chk("satn_corner", d, 16'h7FFF);
    rd_a(12, d); chk("satn_c", d, 16'h7FFF);
    rd_a(24, d); chk("satn_last", d, 16'h7FFF);

    // Positive weight times most-negative source clamps low.
    cfg(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 10'd1);
    run_a(lat);
    rd_a(0,  d); chk("satlo_corner", d, 16'h8000);
    rd_a(12, d); chk("satlo_c", d, 16'h8000);

    // Reset mid-ITER; a start issued during ITER must be ignored.
    fill(16'h0000); src[12] = 16'h0100;
    cfg(16'h0040, 16'h0040, 16'h0040, 16'h0000, 16'h0000, 10'd100);
    start_load();
    repeat (2) @(negedge CLK);
    start = 1; @(negedge CLK);
    start = 0; @(negedge CLK);
    chk("iter_mid", iter_count, 4);
    chk("iter_busy", busy, 1);
    chk("iter_nostart", load_ready, 0);
    R = 1;
    @(negedge CLK);
    chk("rst2_busy", busy, 0);
    chk("rst2_done", done, 0);
    chk("rst2_iter", iter_count, 0);
    chk("rst2_rd", rd_data, 0);
    R = 0;
    for (int k = 0; k < 25; k++) begin
      rd_a(k, d); chk($sformatf("rst2_u%0d", k), d, 16'h0000);
    end

    // 3x4 grid, load_valid toggling; junk on idle cycles must not land.
    for (int k = 0; k < 12; k++) srcb[k] = 16'(16'h0101 * (k + 1));
    srcb[5] = 16'hF123;
    @(negedge CLK); start_b = 1;
    @(negedge CLK); start_b = 0;
    for (int c = 0; c < 24; c++) begin
      load_valid_b = (c % 2 == 0);
      load_data_b  = (c % 2 == 0) ? srcb[c/2] : 16'hBEEF;
      @(negedge CLK);
    end
    load_valid_b = 0;
    chk("b_ready_after", load_ready_b, 0);
    lat = 0;
    while (!done_b && lat < 50) begin
      @(negedge CLK); lat++;
    end
    chk("b_done", done_b, 1);
    chk("b_iter", iter_count_b, 1);
    chk("b_conv", converged_b, 0);
    for (int k = 0; k < 12; k++) begin
      rd_addr_b = 4'(k);
      @(negedge CLK);
      chk($sformatf("b_u%0d", k), rd_data_b, srcb[k]);
    end
    rd_addr_b = 4'd15;
    @(negedge CLK);
    chk("b_oob", rd_data_b, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
